// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter.
// The master drives the controls; the counter (slave) returns count, tc and ovf.
interface param_updown_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up_dn, load, load_val, clr, ovf_clr,
        input  count, tc, ovf
    );

    modport slave (
        input  en, up_dn, load, load_val, clr, ovf_clr,
        output count, tc, ovf
    );
endinterface

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter: load with clamp, clear, wrap or saturate at the
// boundary, combinational cascade terminal count and a sticky overflow flag.
module param_updown_counter #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input logic                   clk,
    input logic                   rst,
    param_updown_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

    // Loads above MAX are clamped so the count never leaves 0..MAX.
    function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] result;
        if (value > MAX) begin
            result = MAX;
        end else begin
            result = value;
        end
        return result;
    endfunction

    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] result;
        if (value == MAX) begin
            result = SATURATE ? MAX : ZERO;
        end else begin
            result = value + ONE;
        end
        return result;
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] result;
        if (value == ZERO) begin
            result = SATURATE ? ZERO : MAX;
        end else begin
            result = value - ONE;
        end
        return result;
    endfunction

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic             tc_s;
    logic             boundary_s;

    // Terminal count ignores clr/load so a chained stage steps once per wrap.
    always_comb begin
        at_max_s   = (count_r == MAX);
        at_zero_s  = (count_r == ZERO);
        tc_s       = bus.en & ((bus.up_dn & at_max_s) | (~bus.up_dn & at_zero_s));
        boundary_s = tc_s & ~bus.clr & ~bus.load;
    end

    // Next count with priority clr > load > en > hold; ovf set beats ovf_clr.
    always_comb begin
        count_nxt_s = count_r;
        if (bus.clr) begin
            count_nxt_s = ZERO;
        end else if (bus.load) begin
            count_nxt_s = clamp_to_max(bus.load_val);
        end else if (bus.en) begin
            if (bus.up_dn) begin
                count_nxt_s = step_up(count_r);
            end else begin
                count_nxt_s = step_down(count_r);
            end
        end else begin
            count_nxt_s = count_r;
        end

        ovf_nxt_s = ovf_r;
        if (boundary_s) begin
            ovf_nxt_s = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // State registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= ZERO;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    assign bus.count = count_r;
    assign bus.tc    = tc_s;
    assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: driver pushes hand-computed expectations into a queue, a
// monitor pops one entry each cycle (#1 after the rising edge) and compares.
module tb_param_updown_counter;
    logic clk;
    logic rst;

    param_updown_counter_if #(.WIDTH(4)) if0 ();
    param_updown_counter_if #(.WIDTH(4)) if1 ();
    param_updown_counter_if #(.WIDTH(4)) if2 ();
    param_updown_counter_if #(.WIDTH(4)) ifc0 ();
    param_updown_counter_if #(.WIDTH(4)) ifc1 ();

    param_updown_counter #(.WIDTH(4), .MAX(4'd15), .SATURATE(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    param_updown_counter #(.WIDTH(4), .MAX(4'd9),  .SATURATE(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    param_updown_counter #(.WIDTH(4), .MAX(4'd9),  .SATURATE(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));
    param_updown_counter #(.WIDTH(4), .MAX(4'd9),  .SATURATE(1'b0)) uc0 (.clk(clk), .rst(rst), .bus(ifc0));
    param_updown_counter #(.WIDTH(4), .MAX(4'd9),  .SATURATE(1'b0)) uc1 (.clk(clk), .rst(rst), .bus(ifc1));

    assign ifc1.en = ifc0.tc;

    typedef struct {
        int         dut;
        logic [7:0] count;
        logic       tc;
        logic       ovf;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic logic [9:0] dut_out(input int d);
        logic [9:0] r;
        case (d)
            0:       r = {4'h0, if0.count, if0.tc, if0.ovf};
            1:       r = {4'h0, if1.count, if1.tc, if1.ovf};
            2:       r = {4'h0, if2.count, if2.tc, if2.ovf};
            default: r = {ifc1.count, ifc0.count, ifc1.tc, ifc1.ovf};
        endcase
        return r;
    endfunction

    task automatic idle_all();
        if0.en = 1'b0;  if0.up_dn = 1'b0;  if0.load = 1'b0;  if0.load_val = 4'd0;  if0.clr = 1'b0;  if0.ovf_clr = 1'b0;
        if1.en = 1'b0;  if1.up_dn = 1'b0;  if1.load = 1'b0;  if1.load_val = 4'd0;  if1.clr = 1'b0;  if1.ovf_clr = 1'b0;
        if2.en = 1'b0;  if2.up_dn = 1'b0;  if2.load = 1'b0;  if2.load_val = 4'd0;  if2.clr = 1'b0;  if2.ovf_clr = 1'b0;
        ifc0.en = 1'b0; ifc0.up_dn = 1'b0; ifc0.load = 1'b0; ifc0.load_val = 4'd0; ifc0.clr = 1'b0; ifc0.ovf_clr = 1'b0;
        ifc1.up_dn = 1'b1; ifc1.load = 1'b0; ifc1.load_val = 4'd0; ifc1.clr = 1'b0; ifc1.ovf_clr = 1'b0;
    endtask

    task automatic set_and_push(input int d, input logic e, input logic u, input logic ld,
                                input logic [3:0] lv, input logic c, input logic oc,
                                input logic [7:0] ec, input logic et, input logic eo, input string nm);
        exp_t x;
        idle_all();
        case (d)
            0: begin if0.en = e; if0.up_dn = u; if0.load = ld; if0.load_val = lv; if0.clr = c; if0.ovf_clr = oc; end
            1: begin if1.en = e; if1.up_dn = u; if1.load = ld; if1.load_val = lv; if1.clr = c; if1.ovf_clr = oc; end
            2: begin if2.en = e; if2.up_dn = u; if2.load = ld; if2.load_val = lv; if2.clr = c; if2.ovf_clr = oc; end
            default: begin ifc0.en = e; ifc0.up_dn = u; ifc0.load = ld; ifc0.load_val = lv; ifc0.clr = c; ifc0.ovf_clr = oc; end
        endcase
        x.dut = d; x.count = ec; x.tc = et; x.ovf = eo; x.name = nm;
        exp_q.push_back(x);
    endtask

    task automatic drive(input int d, input logic e, input logic u, input logic ld,
                         input logic [3:0] lv, input logic c, input logic oc,
                         input logic [7:0] ec, input logic et, input logic eo, input string nm);
        @(negedge clk);
        set_and_push(d, e, u, ld, lv, c, oc, ec, et, eo, nm);
    endtask

    // Monitor: one expectation per cycle, sampled just after the rising edge.
    initial begin
        exp_t       e;
        logic [9:0] o;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = dut_out(e.dut);
                check({e.name, " count"}, o[9:2], e.count);
                check({e.name, " tc"}, {7'd0, o[1]}, {7'd0, e.tc});
                check({e.name, " ovf"}, {7'd0, o[0]}, {7'd0, e.ovf});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        idle_all();
        #50;
        check("reset count", {4'd0, if0.count}, 8'd0);
        check("reset ovf", {7'd0, if0.ovf}, 8'd0);
        check("reset tc idle", {7'd0, if0.tc}, 8'd0);
        if0.en = 1'b1;
        if0.up_dn = 1'b0;
        #1;
        check("reset tc down at 0", {7'd0, if0.tc}, 8'd1);
        if0.en = 1'b0;
        while ($time < 100) @(negedge clk);
        rst = 1'b1;

        // MAX=15 wrap: 1..15,0,1,2,3; tc only at 15; ovf sticky from the 15->0 edge
        for (int k = 1; k <= 19; k++)
            drive(0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'(k % 16), 1'(k == 15), 1'(k >= 16), "up15");

        // Priority, hold, ovf_clr versus boundary event, direction change
        drive(0, 1'b1, 1'b1, 1'b1, 4'd5,  1'b1, 1'b0, 8'd0,  1'b0, 1'b1, "prio_clr");
        drive(0, 1'b1, 1'b1, 1'b1, 4'd5,  1'b0, 1'b0, 8'd5,  1'b0, 1'b1, "prio_load");
        drive(0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 8'd5,  1'b0, 1'b1, "hold");
        drive(0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 8'd15, 1'b0, 1'b1, "load15");
        drive(0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 8'd0,  1'b0, 1'b1, "ovfclr_vs_event");
        drive(0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 8'd0,  1'b0, 1'b0, "ovfclr_alone");
        drive(0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 8'd15, 1'b0, 1'b1, "down_wrap15");
        drive(0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 8'd0,  1'b0, 1'b1, "dir_change");
        drive(0, 1'b0, 1'b1, 1'b1, 4'd7,  1'b0, 1'b0, 8'd7,  1'b0, 1'b1, "load7");

        // Asynchronous reset between edges at count=7, ovf=1
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async rst count", {4'd0, if0.count}, 8'd0);
        check("async rst ovf", {7'd0, if0.ovf}, 8'd0);
        for (int k = 0; k < 3; k++)
            drive(0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, "rst_hold");
        @(negedge clk);
        rst = 1'b1;
        set_and_push(0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, "post_rst");

        // Decade down count from 3 with wrap 0->9, then clamp and up wrap
        drive(1, 1'b0, 1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 8'd3, 1'b0, 1'b0, "dec_ld3");
        drive(1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 8'd2, 1'b0, 1'b0, "dec_dn2");
        drive(1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 8'd1, 1'b0, 1'b0, "dec_dn1");
        drive(1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 8'd0, 1'b1, 1'b0, "dec_dn0");
        drive(1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 8'd9, 1'b0, 1'b1, "dec_wrap9");
        drive(1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 8'd8, 1'b0, 1'b1, "dec_dn8");
        drive(1, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 8'd9, 1'b0, 1'b1, "dec_clamp12");
        drive(1, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 8'd0, 1'b0, 1'b1, "dec_up_wrap");

        // Saturating decade: hold at 9 going up, hold at 0 going down
        drive(2, 1'b0, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0, 8'd8, 1'b0, 1'b0, "sat_ld8");
        drive(2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b0, "sat_up9");
        drive(2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b1, "sat_hold9a");
        drive(2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b1, "sat_hold9b");
        drive(2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd8, 1'b0, 1'b1, "sat_dn8");
        for (int k = 7; k >= 0; k--)
            drive(2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'(k), 1'(k == 0), 1'b1, "sat_dn");
        drive(2, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 8'd0, 1'b1, 1'b1, "sat_hold0a");
        drive(2, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 8'd0, 1'b1, 1'b1, "sat_hold0b");
        drive(2, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 8'd9, 1'b0, 1'b1, "sat_clamp15");

        // Two-decade cascade: 01..99, 00..20; stage1 tc at 99, stage1 ovf from 99->00
        for (int k = 1; k <= 120; k++)
            drive(3, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0,
                  {4'((k % 100) / 10), 4'((k % 100) % 10)}, 1'((k % 100) == 99), 1'(k >= 100), "cascade");

        @(negedge clk);
        idle_all();
        repeat (4) @(negedge clk);
        check("queue drained", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised synchronous up/down counter for the Counters library. Successor to the fixed 4-bit up counter: configurable width and modulus, direction control, count enable, parallel load, synchronous clear, wrap or saturate mode, a cascade terminal-count output and a sticky overflow flag. Used standalone or chained (tc → en of next stage) to build wide or multi-decade counters.

## Interface
- WIDTH, 4, counter width in bits (1..32)
- MAX, 2**WIDTH-1, highest count value (modulus-1), 1 ≤ MAX ≤ 2**WIDTH-1
- SATURATE, 0, 0 = wrap at boundary; 1 = hold at boundary

- clk  input  1  rising-edge clock, the only clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  count enable
- up_dn  input  1  direction: 1 = up, 0 = down
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value loaded when load=1
- clr  input  1  synchronous clear to 0
- ovf_clr  input  1  clears sticky ovf
- count  output  WIDTH  registered count
- tc  output  1  combinational terminal count (cascade carry/borrow)
- ovf  output  1  registered sticky boundary-event flag

## Operation
- Reset (rst=0, asynchronous, no clock needed): count=0, ovf=0. tc follows its equation (0 unless en=1 and up_dn=0 at count 0).
- Per rising edge, priority clr > load > en > hold:
  - clr=1: count←0; ovf unaffected by clr.
  - load=1: count←load_val if load_val ≤ MAX, else count←MAX (clamp).
  - en=1, up_dn=1: count<MAX → count+1; count==MAX → 0 (SATURATE=0) or MAX (SATURATE=1).
  - en=1, up_dn=0: count>0 → count-1; count==0 → MAX (SATURATE=0) or 0 (SATURATE=1).
  - otherwise count holds.
- Boundary event = en=1 and clr=0 and load=0 and (up_dn=1 and count==MAX, or up_dn=0 and count==0). Applies in both modes.
- ovf: set on clock edge with boundary event; cleared by ovf_clr=1; if both same cycle, set wins (ovf stays 1).
- tc = en & ((up_dn & count==MAX) | (~up_dn & count==0)). Purely combinational, ignores clr/load, so a chained next stage advances exactly once per wrap of this stage.
- Arithmetic in WIDTH bits; count never exceeds MAX in any state reachable from reset, including after load.
- Changing up_dn mid-count: direction takes effect on the next edge, no extra step or skip.

## Timing
- Latency: every control input affects count on the first rising edge after it is sampled (1 cycle).
- tc valid in the same cycle as count/en/up_dn, zero latency; consumer samples it on the next edge.
- ovf rises on the same edge that count performs the wrap/saturate step.
- rst assertion mid-operation forces count=0, ovf=0 immediately; on deassertion the first counting edge is the first rising clk with rst=1 (deassertion assumed synchronous to clk by the integrator's reset synchroniser).
- No multicycle paths; tc is the only combinational output and must meet single-cycle timing into a following stage.

## Test plan
- WIDTH=4, MAX=15, SATURATE=0; rst low 100 ns then high, en=1, up_dn=1 for 20 cycles -> count 0,1,…,15,0,1,2,3; tc=1 only while count==15; ovf becomes 1 on the 15→0 edge and stays 1.
- WIDTH=4, MAX=9 (decade); down count from load_val=3 -> 3,2,1,0,9,8; tc=1 while count==0; ovf set on 0→9; load_val=12 -> count=9 (clamp).
- SATURATE=1, MAX=9: up from 8 -> 9,9,9 with tc=1 and ovf=1; switch up_dn=0 -> 8,7; down to 0 -> holds 0.
- Priority: clr=1, load=1 (load_val=5), en=1 same cycle -> count=0; then load=1, en=1 -> count=5; en=0 -> holds 5; ovf_clr=1 coincident with boundary event -> ovf remains 1; ovf_clr alone -> ovf=0.
- Cascade: two MAX=9 instances, stage1 en=stage0 tc, 120 cycles en=1 up -> combined value 00…99 then 00, stage1 increments exactly once per stage0 9→0.
- Async reset: pull rst low between clock edges at count=7, ovf=1 -> count=0 and ovf=0 before next edge; hold rst low 3 edges with en=1 -> count stays 0.
